// File: rtl/smartcart_path_pkg.sv
// -----------------------------------------------------------------------------
// smartcart_path_pkg
// Shared types for the pathfinding result path: node records, the path-array
// depth, the streamer state enum and the word-field enum used while
// serialising a path frame.
// Optional feature macro used by the files that import this package:
//   PATH_STREAMER_CHECKSUM_EN - append an XOR checksum word to each frame.
// -----------------------------------------------------------------------------
package smartcart_path_pkg;

   localparam int MAX_PATH_NODES = 100;
   localparam int FIELD_W        = 16;
   // Node index / length width: covers 0..MAX_PATH_NODES.
   localparam int IDX_W          = 7;

   typedef struct packed {
      logic [FIELD_W-1:0] x;
      logic [FIELD_W-1:0] y;
   } map_node;

   typedef struct packed {
      logic [FIELD_W-1:0] node_id;
      map_node            pos;
   } node_info;

   typedef enum logic {
      IDLE,
      STREAM
   } stream_state_e;

   // Word currently held in the output register.
   typedef enum logic [1:0] {
      FLD_HDR,
      FLD_ID,
      FLD_X,
      FLD_Y
   } field_e;

   // Engine length clamped to [0, max_n]; a negative length means an empty frame.
   function automatic logic [IDX_W-1:0] clamp_len(input logic signed [31:0] raw,
                                                  input int max_n);
      if (raw < 0)
         return '0;
      if (raw > max_n)
         return IDX_W'(max_n);
      return raw[IDX_W-1:0];
   endfunction

endpackage

// File: rtl/path_streamer_if.sv
// -----------------------------------------------------------------------------
// path_streamer_if
// Valid/ready word stream from the path streamer to the HPS bridge FIFO.
//   out_data  : stream word
//   out_valid : out_data valid
//   out_ready : sink accepts the word when out_valid && out_ready
//   out_last  : final word of the frame
// Modports: master (streamer side), slave (sink side).
// -----------------------------------------------------------------------------
interface path_streamer_if #(
   parameter int WORD_W = 16
);
   logic [WORD_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/path_word_seq.sv
// -----------------------------------------------------------------------------
// path_word_seq
// Position counters for a path frame: header, then node index 0..len-1 with
// field order id -> x -> y, and (with PATH_STREAMER_CHECKSUM_EN) a trailing
// checksum word. Holds the position of the word currently on the output and
// presents the position of the following word so the parent can preload it.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   start      : load a new frame of length len (position -> header)
//   advance    : current word handshaken and it was not the last one
//   len        : clamped node count, sampled on start
//   nxt_idx    : node index of the following word
//   nxt_fld    : field of the following word
//   nxt_sum    : following word is the checksum (PATH_STREAMER_CHECKSUM_EN only)
//   last       : current word is the final word of the frame
// -----------------------------------------------------------------------------
module path_word_seq
   import smartcart_path_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             advance,
   input  logic [IDX_W-1:0] len,
   output logic [IDX_W-1:0] nxt_idx,
   output field_e           nxt_fld,
`ifdef PATH_STREAMER_CHECKSUM_EN
   output logic             nxt_sum,
`endif
   output logic             last
);

   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] len_q;
   field_e           fld_q;
   logic             data_end;

   // Last data-carrying word: the header of an empty frame or y of the final node.
   assign data_end = ((fld_q == FLD_HDR) && (len_q == '0)) ||
                     ((fld_q == FLD_Y) && (idx_q == len_q - IDX_W'(1)));

`ifdef PATH_STREAMER_CHECKSUM_EN
   logic sum_q;
   assign last = sum_q;
`else
   assign last = data_end;
`endif

   always_comb begin
      nxt_idx = idx_q;
      nxt_fld = fld_q;
      case (fld_q)
         FLD_HDR: nxt_fld = FLD_ID;
         FLD_ID:  nxt_fld = FLD_X;
         FLD_X:   nxt_fld = FLD_Y;
         FLD_Y: begin
            if (!data_end) begin
               nxt_idx = idx_q + IDX_W'(1);
               nxt_fld = FLD_ID;
            end
         end
      endcase
`ifdef PATH_STREAMER_CHECKSUM_EN
      // The checksum word follows whatever data word ends the frame.
      nxt_sum = sum_q | data_end;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q <= '0;
         len_q <= '0;
         fld_q <= FLD_HDR;
`ifdef PATH_STREAMER_CHECKSUM_EN
         sum_q <= 1'b0;
`endif
      end else if (start) begin
         idx_q <= '0;
         len_q <= len;
         fld_q <= FLD_HDR;
`ifdef PATH_STREAMER_CHECKSUM_EN
         sum_q <= 1'b0;
`endif
      end else if (advance) begin
         idx_q <= nxt_idx;
         fld_q <= nxt_fld;
`ifdef PATH_STREAMER_CHECKSUM_EN
         sum_q <= nxt_sum;
`endif
      end
   end

endmodule

// File: rtl/path_streamer.sv
// -----------------------------------------------------------------------------
// path_streamer
// Consumer end of the pathfinding engine's result interface. On the rising
// edge of success it snapshots the path array and streams it as
//   header (node count), then node_id, x, y per node in index order
// over a 16-bit valid/ready stream. Build option:
//   PATH_STREAMER_CHECKSUM_EN - append one word = XOR of all preceding frame
//                               words; out_last moves to that word.
// Ports:
//   clk      : clock (rising edge)
//   reset    : asynchronous active-low reset
//   success  : engine done level; a frame starts on its rising edge
//   path     : engine path array, valid in the success-rise cycle
//   path_len : signed node count from the engine
//   stream   : word stream (master modport)
//   busy     : frame in progress
//   overrun  : path_len was out of [0, MAX_NODES]; held until the next frame
//   dropped  : one-cycle pulse when a success rise is ignored mid-frame
// -----------------------------------------------------------------------------
module path_streamer
   import smartcart_path_pkg::*;
#(
   parameter int MAX_NODES = MAX_PATH_NODES,
   parameter int WORD_W    = FIELD_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   success,
   input  node_info               path [MAX_NODES],
   input  logic signed [31:0]     path_len,
   path_streamer_if.master        stream,
   output logic                   busy,
   output logic                   overrun,
   output logic                   dropped
);

   stream_state_e    state_q, state_d;
   logic             succ_q;
   logic             trigger, hs, fin, accept, drop_d;
   logic [IDX_W-1:0] len_c;
   logic [IDX_W-1:0] nxt_idx;
   field_e           nxt_fld;
   logic             seq_last;
   node_info         snap [MAX_NODES];
   logic [WORD_W-1:0] data_q, word_d;
   logic             overrun_q, dropped_q;
`ifdef PATH_STREAMER_CHECKSUM_EN
   logic             nxt_sum;
   logic [WORD_W-1:0] csum_q;
`endif

   assign trigger = success && !succ_q;
   assign len_c   = clamp_len(path_len, MAX_NODES);
   assign hs      = (state_q == STREAM) && stream.out_ready;
   assign fin     = hs && seq_last;

   path_word_seq u_seq (
      .clk     (clk),
      .reset   (reset),
      .start   (accept),
      .advance (hs && !seq_last),
      .len     (len_c),
      .nxt_idx (nxt_idx),
      .nxt_fld (nxt_fld),
`ifdef PATH_STREAMER_CHECKSUM_EN
      .nxt_sum (nxt_sum),
`endif
      .last    (seq_last)
   );

   // A rise landing on the final handshake starts the next frame straight away.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      drop_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               accept  = 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (fin) begin
               if (trigger)
                  accept = 1'b1;
               else
                  state_d = IDLE;
            end else if (trigger) begin
               drop_d = 1'b1;
            end
         end
      endcase
   end

   // Word that replaces the current one after its handshake.
   always_comb begin
      word_d = data_q;
      case (nxt_fld)
         FLD_ID:  word_d = snap[nxt_idx].node_id;
         FLD_X:   word_d = snap[nxt_idx].pos.x;
         FLD_Y:   word_d = snap[nxt_idx].pos.y;
         default: word_d = data_q;
      endcase
`ifdef PATH_STREAMER_CHECKSUM_EN
      if (nxt_sum)
         word_d = csum_q ^ data_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (accept)
         snap <= path;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         succ_q    <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
         dropped_q <= 1'b0;
`ifdef PATH_STREAMER_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         succ_q    <= success;
         dropped_q <= drop_d;
         if (accept) begin
            data_q    <= WORD_W'(len_c);
            overrun_q <= (path_len < 0) || (path_len > MAX_NODES);
`ifdef PATH_STREAMER_CHECKSUM_EN
            csum_q    <= '0;
`endif
         end else if (hs && !seq_last) begin
            data_q <= word_d;
`ifdef PATH_STREAMER_CHECKSUM_EN
            csum_q <= csum_q ^ data_q;
`endif
         end
      end
   end

   assign stream.out_valid = (state_q == STREAM);
   assign stream.out_last  = (state_q == STREAM) && seq_last;
   assign stream.out_data  = data_q;
   assign busy             = (state_q == STREAM);
   assign overrun          = overrun_q;
   assign dropped          = dropped_q;

endmodule

// File: tb/tb_path_streamer.sv
// -----------------------------------------------------------------------------
// tb_path_streamer
// Scoreboard bench for path_streamer: expected frame words are queued when a
// frame is launched; a negedge monitor compares every presented word against
// the queue head and pops it on handshake.
// Honours PATH_STREAMER_CHECKSUM_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_path_streamer;
   import smartcart_path_pkg::*;

   localparam int N = MAX_PATH_NODES;
`ifdef PATH_STREAMER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   localparam int BASE_CYC = 8 + int'(CSUM);

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               success = 1'b0;
   node_info           path [N];
   logic signed [31:0] path_len = 0;
   logic               busy, overrun, dropped;
   logic               bp = 1'b0;

   path_streamer_if #(.WORD_W(16)) sif ();

   path_streamer #(.MAX_NODES(N), .WORD_W(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .success  (success),
      .path     (path),
      .path_len (path_len),
      .stream   (sif),
      .busy     (busy),
      .overrun  (overrun),
      .dropped  (dropped)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   logic [15:0] base_words [7] = '{16'h0002, 16'h0013, 16'h0010, 16'h0010,
                                   16'h0045, 16'h0082, 16'h0043};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   task automatic push(input logic [15:0] d, input logic l);
      exp_t e;
      e.data = d;
      e.last = l;
      exp_q.push_back(e);
   endtask

   task automatic fill_pattern;
      for (int i = 0; i < N; i++) begin
         path[i].node_id = 16'(16'h0A00 + i);
         path[i].pos.x   = 16'(16'h1100 + 2 * i);
         path[i].pos.y   = 16'(16'h2200 + 3 * i);
      end
   endtask

   task automatic set_base;
      path[0].node_id = 16'h0013; path[0].pos.x = 16'h0010; path[0].pos.y = 16'h0010;
      path[1].node_id = 16'h0045; path[1].pos.x = 16'h0082; path[1].pos.y = 16'h0043;
      path_len = 2;
   endtask

   task automatic push_base;
      for (int i = 0; i < 7; i++)
         push(base_words[i], !CSUM && (i == 6));
      if (CSUM)
         push(16'h0095, 1'b1);
   endtask

   // Expected frame for a clamped length from the bench's own path array.
   task automatic push_model(input int len);
      logic [15:0] sum;
      sum = 16'(len);
      push(16'(len), !CSUM && (len == 0));
      for (int i = 0; i < len; i++) begin
         push(path[i].node_id, 1'b0);
         push(path[i].pos.x, 1'b0);
         push(path[i].pos.y, !CSUM && (i == len - 1));
         sum = sum ^ path[i].node_id ^ path[i].pos.x ^ path[i].pos.y;
      end
      if (CSUM)
         push(sum, 1'b1);
   endtask

   task automatic start_frame;
      @(posedge clk); #1 success = 1'b0;
      @(posedge clk); #1 success = 1'b1;
   endtask

   task automatic wait_drain(input int budget, output int cycles);
      cycles = 0;
      while (exp_q.size() != 0 && cycles < budget) begin
         @(negedge clk); #1;
         cycles++;
      end
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Ready driver: steady high, or toggling every cycle under backpressure.
   initial begin
      sif.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         sif.out_ready = bp ? ~sif.out_ready : 1'b1;
      end
   end

   // Monitor: every valid cycle is checked against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (reset && sif.out_valid) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_word: got %h last=%b, required no word",
                        sif.out_data, sif.out_last);
            end else begin
               chk("word_data", 32'(sif.out_data), 32'(exp_q[0].data));
               chk("word_last", 32'(sif.out_last), 32'(exp_q[0].last));
               if (sif.out_ready)
                  void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required $finish earlier");
      $fatal(1, "tb_path_streamer timeout");
   end

   initial begin
      int cyc;
      fill_pattern();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid",   32'(sif.out_valid), 0);
      chk("rst_data",    32'(sif.out_data), 0);
      chk("rst_last",    32'(sif.out_last), 0);
      chk("rst_busy",    32'(busy), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_dropped", 32'(dropped), 0);
      reset = 1'b1;

      // Base frame, ready held high: header one clock after the rise, no bubbles.
      set_base(); push_base();
      start_frame();
      wait_drain(40, cyc);
      chk("base_cycles", cyc, BASE_CYC);
      chk("base_overrun", 32'(overrun), 0);
      @(negedge clk); #1;
      chk("base_idle_busy", 32'(busy), 0);
      chk("base_idle_valid", 32'(sif.out_valid), 0);

      // Backpressure: same sequence with ready toggling.
      push_base();
      bp = 1'b1;
      start_frame();
      wait_drain(60, cyc);
      bp = 1'b0;

      // Empty path.
      path_len = 0; push_model(0);
      start_frame();
      wait_drain(20, cyc);
      chk("empty_cycles", cyc, 2 + int'(CSUM));
      chk("empty_overrun", 32'(overrun), 0);

      // Length above the array depth is clamped.
      fill_pattern();
      path_len = 150; push_model(100);
      start_frame();
      wait_drain(400, cyc);
      chk("long_cycles", cyc, 302 + int'(CSUM));
      chk("long_overrun", 32'(overrun), 1);

      // Negative length.
      path_len = -1; push_model(0);
      start_frame();
      wait_drain(20, cyc);
      chk("neg_overrun", 32'(overrun), 1);

      // Retrigger mid-frame with altered inputs: frame keeps its snapshot.
      set_base(); push_base();
      start_frame();
      @(posedge clk); #1;
      success = 1'b0;
      path[0].node_id = 16'hDEAD;
      path_len = 5;
      @(posedge clk); #1 success = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      chk("retrig_dropped", 32'(dropped), 1);
      chk("retrig_busy", 32'(busy), 1);
      @(negedge clk); #1;
      chk("retrig_dropped_end", 32'(dropped), 0);
      wait_drain(40, cyc);
      chk("retrig_overrun_cleared", 32'(overrun), 0);

      // Success held high after the frame: nothing restarts.
      repeat (10) @(negedge clk);
      #1;
      chk("held_busy", 32'(busy), 0);

      // Reset in the middle of a frame.
      set_base(); push_base();
      start_frame();
      cyc = 0;
      while (exp_q.size() > 4 + int'(CSUM) && cyc < 20) begin
         @(negedge clk); #1;
         cyc++;
      end
      chk("mid_reached", exp_q.size(), 4 + int'(CSUM));
      reset = 1'b0;
      success = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_valid", 32'(sif.out_valid), 0);
      chk("midrst_data", 32'(sif.out_data), 0);
      chk("midrst_last", 32'(sif.out_last), 0);
      chk("midrst_busy", 32'(busy), 0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_busy", 32'(busy), 0);

      // Fresh frame after reset starts from the header.
      push_base();
      start_frame();
      wait_drain(40, cyc);
      chk("restart_cycles", cyc, BASE_CYC);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
